// File: rtl/store_rmw_ctrl.sv
// Memory-stage sequencer: direct word stores, read-modify-write for byte/halfword
// stores through an external masking block, and single-word loads with pipeline stall.
module store_rmw_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [1:0]        req_size,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [1:0]        mrg_byte_addr,
    output logic [31:0]       mrg_mem_data,
    output logic [31:0]       mrg_reg_data,
    output logic [1:0]        mrg_size,
    input  logic [31:0]       mrg_result
);

    typedef enum logic [2:0] {IDLE, RD, MG, WR, LC} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W+1:0]   addr_q;
    logic [1:0]          size_q;
    logic [31:0]         wdata_q;
    logic                write_q;
    logic                misaligned;
    logic                word_req;
    logic [31:ADDR_W+2]  unused_addr_hi;

    // Upper byte-address bits wrap within the memory depth.
    assign unused_addr_hi = req_addr[31:ADDR_W+2];

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'd1:    return 1'b0;
            2'd2:    return addr_lo[0];
            default: return addr_lo != 2'd0;
        endcase
    endfunction

    assign misaligned = is_misaligned(req_size, req_addr[1:0]);
    assign word_req   = (req_size == 2'd0) || (req_size == 2'd3);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req_valid && !misaligned) begin
                    if (req_write && word_req) state_nxt = WR;
                    else                       state_nxt = RD;
                end
            end
            RD:      state_nxt = write_q ? MG : LC;
            MG:      state_nxt = WR;
            WR:      state_nxt = IDLE;
            LC:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready    = 1'b0;
        stall        = 1'b1;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mrg_mem_data = 32'd0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                stall     = 1'b0;
            end
            RD:  mem_en = 1'b1;
            MG:  mrg_mem_data = mem_rdata;
            WR: begin
                mem_en = 1'b1;
                mem_we = 1'b1;
            end
            default: ;
        endcase
    end

    // Request capture, merge write-back and response registers.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            addr_q    <= '0;
            size_q    <= 2'd0;
            wdata_q   <= 32'd0;
            write_q   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            err       <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr[ADDR_W+1:0];
                        size_q  <= req_size;
                        wdata_q <= req_wdata;
                        write_q <= req_write;
                        err     <= misaligned;
                    end
                end
                MG: wdata_q <= mrg_result;
                LC: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr      = addr_q[ADDR_W+1:2];
    assign mem_wdata     = wdata_q;
    assign mrg_byte_addr = addr_q[1:0];
    assign mrg_reg_data  = wdata_q;
    assign mrg_size      = size_q;

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Bench for store_rmw_ctrl: memory and masking block models, a per-cycle
// expectation schedule derived from request semantics, directed and random stimulus.
module tb_store_rmw_ctrl;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              Clk, Rst;
    logic              req_valid, req_ready, req_write;
    logic [31:0]       req_addr, req_wdata;
    logic [1:0]        req_size;
    logic              stall, rsp_valid, err, mem_en, mem_we;
    logic [31:0]       rsp_rdata, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mrg_byte_addr, mrg_size;
    logic [31:0]       mrg_mem_data, mrg_reg_data, mrg_result;

    store_rmw_ctrl #(.ADDR_W(ADDR_W)) dut (
        .Clk(Clk), .Rst(Rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .err(err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mrg_byte_addr(mrg_byte_addr), .mrg_mem_data(mrg_mem_data),
        .mrg_reg_data(mrg_reg_data), .mrg_size(mrg_size), .mrg_result(mrg_result)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Synchronous-read data memory.
    logic [31:0] mem [DEPTH];
    always @(posedge Clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    // Store-masking block (mask-and-shift form).
    logic [31:0] mrg_mask;
    always_comb begin
        mrg_mask = 32'hFFFF_FFFF;
        case (mrg_size)
            2'd1:    mrg_mask = 32'h0000_00FF << {mrg_byte_addr, 3'b000};
            2'd2:    mrg_mask = 32'h0000_FFFF << {mrg_byte_addr, 3'b000};
            default: mrg_mask = 32'hFFFF_FFFF;
        endcase
        mrg_result = (mrg_mem_data & ~mrg_mask) | ((mrg_reg_data << {mrg_byte_addr, 3'b000}) & mrg_mask);
    end

    // Reference model: memory image plus expected observable behaviour per cycle.
    typedef struct {
        bit                busy, en, we, err, rsp, mg;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata, rdata, mmd, mrd;
        logic [1:0]        mba, msz;
    } slot_t;

    logic [31:0] mem_ref [DEPTH];
    slot_t       sl [16];
    logic [31:0] model_rsp;
    int          cyc, checks, errors;

    function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] data,
                                                input logic [1:0] ba, input logic [1:0] sz);
        logic [31:0] r = old;
        if (sz == 2'd1)      r[{ba, 3'b000} +: 8]     = data[7:0];
        else if (sz == 2'd2) r[{ba[1], 4'b0000} +: 16] = data[15:0];
        else                 r = data;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) sl[i] = '{default: '0};
        model_rsp = 32'd0;
    endtask

    task automatic check_slot(output bit busy);
        slot_t s;
        s = sl[cyc % 16];
        if (s.rsp) model_rsp = s.rdata;
        chk("req_ready", 32'(req_ready), 32'(!s.busy));
        chk("stall", 32'(stall), 32'(s.busy));
        chk("mem_en", 32'(mem_en), 32'(s.en));
        chk("mem_we", 32'(mem_we), 32'(s.we));
        chk("err", 32'(err), 32'(s.err));
        chk("rsp_valid", 32'(rsp_valid), 32'(s.rsp));
        chk("rsp_rdata", rsp_rdata, model_rsp);
        if (s.en) chk("mem_addr", 32'(mem_addr), 32'(s.addr));
        if (s.en && s.we) chk("mem_wdata", mem_wdata, s.wdata);
        if (s.mg) begin
            chk("mrg_byte_addr", 32'(mrg_byte_addr), 32'(s.mba));
            chk("mrg_size", 32'(mrg_size), 32'(s.msz));
            chk("mrg_mem_data", mrg_mem_data, s.mmd);
            chk("mrg_reg_data", mrg_reg_data, s.mrd);
        end
        busy = s.busy;
        sl[cyc % 16] = '{default: '0};
    endtask

    task automatic schedule(input logic w, input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        logic [ADDR_W-1:0] wa;
        logic [1:0]        ba;
        logic [31:0]       merged;
        bit                word, mis;
        int                k1, k2, k3;
        wa   = a[ADDR_W+1:2];
        ba   = a[1:0];
        word = (s == 2'd0) || (s == 2'd3);
        mis  = (s == 2'd2 && a[0]) || (word && ba != 2'd0);
        k1 = (cyc + 1) % 16; k2 = (cyc + 2) % 16; k3 = (cyc + 3) % 16;
        if (mis) begin
            sl[k1].err = 1'b1;
        end else if (w && word) begin
            sl[k1].busy = 1; sl[k1].en = 1; sl[k1].we = 1; sl[k1].addr = wa; sl[k1].wdata = d;
            mem_ref[wa] = d;
        end else if (w) begin
            merged = model_merge(mem_ref[wa], d, ba, s);
            sl[k1].busy = 1; sl[k1].en = 1; sl[k1].addr = wa;
            sl[k2].busy = 1; sl[k2].mg = 1; sl[k2].mba = ba; sl[k2].msz = s;
            sl[k2].mmd = mem_ref[wa]; sl[k2].mrd = d;
            sl[k3].busy = 1; sl[k3].en = 1; sl[k3].we = 1; sl[k3].addr = wa; sl[k3].wdata = merged;
            mem_ref[wa] = merged;
        end else begin
            sl[k1].busy = 1; sl[k1].en = 1; sl[k1].addr = wa;
            sl[k2].busy = 1;
            sl[k3].rsp = 1; sl[k3].rdata = mem_ref[wa];
        end
    endtask

    // One clock cycle: check outputs, drive this cycle's request, record acceptance.
    task automatic step(input logic v, input logic w, input logic [31:0] a,
                        input logic [1:0] s, input logic [31:0] d);
        bit busy;
        @(negedge Clk);
        check_slot(busy);
        req_valid = v; req_write = w; req_addr = a; req_size = s; req_wdata = d;
        if (v && !busy) schedule(w, a, s, d);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 2'd0, 32'd0);
    endtask

    logic [31:0] saved;
    logic [31:0] ra, rd;

    initial begin
        checks = 0; errors = 0; cyc = 0;
        clear_model();
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = $urandom;
            mem_ref[i] = mem[i];
        end
        Rst = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_size = 2'd0; req_wdata = 32'd0;
        @(posedge Clk);
        #2;
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset mem_en", 32'(mem_en), 32'd0);
        chk("reset mem_we", 32'(mem_we), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset err", 32'(err), 32'd0);
        @(negedge Clk);
        Rst = 1'b1;

        // Word store then load back.
        step(1, 1, 32'h10, 2'd0, 32'hDEADBEEF);
        idle(2);
        chk("word store mem[4]", mem[4], 32'hDEADBEEF);
        step(1, 0, 32'h10, 2'd0, 32'd0);
        idle(3);
        chk("load 0x10 rsp_valid", 32'(rsp_valid), 32'd1);
        chk("load 0x10 rsp_rdata", rsp_rdata, 32'hDEADBEEF);

        // Byte store into a known word.
        step(1, 1, 32'h10, 2'd3, 32'h11223344);
        idle(1);
        step(1, 1, 32'h13, 2'd1, 32'h000000AA);
        idle(4);
        chk("byte store mem[4]", mem[4], 32'hAA223344);

        // Halfword store with a second one held while stalled.
        step(1, 1, 32'h22, 2'd2, 32'h0000BEEF);
        for (int i = 0; i < 4; i++) step(1, 1, 32'h20, 2'd2, 32'h1234CAFE);
        idle(4);
        chk("halfword pair mem[8]", mem[8], 32'hBEEFCAFE);

        // Misaligned requests.
        step(1, 1, 32'h21, 2'd2, 32'h5555AAAA);
        step(1, 0, 32'h26, 2'd0, 32'd0);
        idle(2);
        chk("misaligned mem[8]", mem[8], 32'hBEEFCAFE);

        // Load immediately followed by a store to the same word.
        step(1, 0, 32'h10, 2'd0, 32'd0);
        for (int i = 0; i < 3; i++) step(1, 1, 32'h10, 2'd0, 32'h55AA55AA);
        idle(3);
        chk("load-before-store rsp_rdata", rsp_rdata, 32'hAA223344);
        chk("load-before-store mem[4]", mem[4], 32'h55AA55AA);

        // Reset during the merge cycle of a byte store.
        saved = mem[12];
        step(1, 1, 32'h31, 2'd1, 32'h000000CD);
        idle(1);
        @(posedge Clk);
        #2 Rst = 1'b0;
        #1;
        chk("midreset req_ready", 32'(req_ready), 32'd1);
        chk("midreset stall", 32'(stall), 32'd0);
        chk("midreset mem_en", 32'(mem_en), 32'd0);
        chk("midreset mem_we", 32'(mem_we), 32'd0);
        chk("midreset rsp_rdata", rsp_rdata, 32'd0);
        chk("midreset err", 32'(err), 32'd0);
        chk("midreset mrg_size", 32'(mrg_size), 32'd0);
        chk("midreset mrg_reg_data", mrg_reg_data, 32'd0);
        chk("midreset mrg_mem_data", mrg_mem_data, 32'd0);
        @(negedge Clk);
        Rst = 1'b1;
        clear_model();
        mem_ref[12] = saved;
        idle(3);
        chk("midreset mem[12] unchanged", mem[12], saved);
        step(1, 0, 32'h30, 2'd0, 32'd0);
        idle(3);
        chk("post-reset load", rsp_rdata, saved);

        // Randomized traffic over a few words, upper address bits random.
        for (int n = 0; n < 3000; n++) begin
            ra = $urandom;
            ra[ADDR_W+1:2] = 10'($urandom_range(0, 15));
            rd = $urandom;
            step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), ra,
                 2'($urandom_range(0, 3)), rd);
        end
        idle(6);
        for (int i = 0; i < DEPTH; i++) chk("final memory image", mem[i], mem_ref[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
